// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract unit: one full-adder cell time-shared over WIDTH bits,
// one bit per clock, with a start/done handshake and NZCV flags.

module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = in1 ^ in2 ^ cin;
   assign cout = (in1 & in2) | (cin & (in1 ^ in2));

endmodule

module serial_add_sequencer #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [CW-1:0]    count_q, count_d;
   logic             carry_q, carry_d;
   logic             cprev_q, cprev_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             negative_q, negative_d;
   logic             zero_q, zero_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic fa_sum;
   logic fa_cout;

   full_adder u_fa (
      .in1  (sh_a_q[0]),
      .in2  (sh_b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state, datapath shifting and registered-output decode
   always_comb begin
      state_d     = state_q;
      sh_a_d      = sh_a_q;
      sh_b_d      = sh_b_q;
      res_sh_d    = res_sh_q;
      count_d     = count_q;
      carry_d     = carry_q;
      cprev_d     = cprev_q;
      result_d    = result_q;
      negative_d  = negative_q;
      zero_d      = zero_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: the +1 enters as the initial carry
               sh_a_d  = a;
               sh_b_d  = sub ? ~b : b;
               carry_d = sub;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sh_a_d   = sh_a_q >> 1;
            sh_b_d   = sh_b_q >> 1;
            res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            count_d  = count_q + CW'(1);
            if (count_q == CNT_PENULT) begin
               cprev_d = fa_cout;
            end
            if (count_q == CNT_LAST) begin
               state_d     = S_DONE;
               result_d    = res_sh_d;
               carry_out_d = fa_cout;
               overflow_d  = cprev_q ^ fa_cout;
               negative_d  = fa_sum;
               zero_d      = (res_sh_d == '0);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sh_a_q      <= '0;
         sh_b_q      <= '0;
         res_sh_q    <= '0;
         count_q     <= '0;
         carry_q     <= 1'b0;
         cprev_q     <= 1'b0;
         result_q    <= '0;
         negative_q  <= 1'b0;
         zero_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_a_q      <= sh_a_d;
         sh_b_q      <= sh_b_d;
         res_sh_q    <= res_sh_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         cprev_q     <= cprev_d;
         result_q    <= result_d;
         negative_q  <= negative_d;
         zero_q      <= zero_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign negative  = negative_q;
   assign zero      = zero_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: directed 8-bit vectors plus a
// back-to-back 64-bit run checked against a wide-arithmetic reference.

module tb_serial_add_sequencer;

   localparam int unsigned W8   = 8;
   localparam int unsigned W64  = 64;
   localparam int unsigned NOPS = 1000;

   typedef struct packed {
      logic [63:0] res;
      logic        n;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset8, start8, sub8, ready8, busy8, done8, n8, z8, c8, v8;
   logic [W8-1:0] a8, b8, res8;
   logic           reset64, start64, sub64, ready64, busy64, done64, n64, z64, c64, v64;
   logic [W64-1:0] a64, b64, res64;

   serial_add_sequencer #(.WIDTH(W8)) u_dut8 (
      .clk(clk), .reset(reset8), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .result(res8),
      .negative(n8), .zero(z8), .carry_out(c8), .overflow(v8)
   );

   serial_add_sequencer #(.WIDTH(W64)) u_dut64 (
      .clk(clk), .reset(reset64), .start(start64), .sub(sub64), .a(a64), .b(b64),
      .ready(ready64), .busy(busy64), .done(done64), .result(res64),
      .negative(n64), .zero(z64), .carry_out(c64), .overflow(v64)
   );

   exp_t q8[$];
   exp_t q64[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] r, input logic n, z, c, v);
      exp_t e;
      e.res = r; e.n = n; e.z = z; e.c = c; e.v = v;
      return e;
   endfunction

   function automatic exp_t model64(input logic [63:0] a, b, input logic s);
      logic [64:0] t;
      exp_t        e;
      if (s) t = {1'b0, a} + {1'b0, ~b} + 65'd1;
      else   t = {1'b0, a} + {1'b0, b};
      e.res = t[63:0];
      e.n   = t[63];
      e.z   = (t[63:0] == 64'd0);
      e.c   = t[64];
      e.v   = s ? ((a[63] != b[63]) && (t[63] != a[63]))
                : ((a[63] == b[63]) && (t[63] != a[63]));
      return e;
   endfunction

   // 8-bit monitor: pops one expectation per done pulse
   logic prev_done8 = 1'b0;
   always @(negedge clk) begin : mon8
      exp_t e;
      if (done8 === 1'b1) begin
         chk("done8_width", 64'(prev_done8), 64'd0);
         if (q8.size() == 0) begin
            chk("done8_unexpected", 64'd1, 64'd0);
         end else begin
            e = q8.pop_front();
            chk("result8", 64'(res8), e.res);
            chk("nzcv8", 64'({n8, z8, c8, v8}), 64'({e.n, e.z, e.c, e.v}));
         end
      end
      prev_done8 = done8;
   end

   // 64-bit monitor: also checks spacing between consecutive completions
   int last_done64 = -1;
   always @(negedge clk) begin : mon64
      exp_t e;
      if (done64 === 1'b1) begin
         if (last_done64 >= 0) chk("period64", 64'(cyc - last_done64), 64'(W64 + 2));
         last_done64 = cyc;
         if (q64.size() == 0) begin
            chk("done64_unexpected", 64'd1, 64'd0);
         end else begin
            e = q64.pop_front();
            chk("result64", res64, e.res);
            chk("nzcv64", 64'({n64, z64, c64, v64}), 64'({e.n, e.z, e.c, e.v}));
         end
      end
   end

   task automatic wait_ready8();
      int g = 0;
      while (ready8 !== 1'b1 && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (g >= 40) chk("ready8_timeout", 64'd0, 64'd1);
   endtask

   // Issue one op; returns at the negedge after the accepting edge
   task automatic issue8(input logic [7:0] a, b, input logic s, input logic push, input exp_t e);
      wait_ready8();
      a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
      if (push) q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'h5A; b8 = 8'hC3; sub8 = ~s;
      chk("ready8_falls", 64'(ready8), 64'd0);
      chk("busy8_rises", 64'(busy8), 64'd1);
   endtask

   // Counts rising edges from the accepting edge (inclusive) to the done cycle
   task automatic wait_done8(input int start_edges, input string nm);
      int edges = start_edges;
      while (done8 !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk(nm, 64'(edges), 64'(W8 + 1));
   endtask

   task automatic chk_idle8(input string nm);
      chk({nm, "_ready"}, 64'(ready8), 64'd1);
      chk({nm, "_busy"}, 64'(busy8), 64'd0);
      chk({nm, "_done"}, 64'(done8), 64'd0);
      chk({nm, "_result"}, 64'(res8), 64'd0);
      chk({nm, "_flags"}, 64'({n8, z8, c8, v8}), 64'd0);
   endtask

   initial begin
      reset8 = 1'b0; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      reset64 = 1'b0; start64 = 1'b0; sub64 = 1'b0; a64 = '0; b64 = '0;
      repeat (2) @(negedge clk);
      chk_idle8("reset8");
      chk("reset64_ready", 64'(ready64), 64'd1);
      chk("reset64_state", 64'({busy64, done64, n64, z64, c64, v64}), 64'd0);
      chk("reset64_result", res64, 64'd0);
      reset8 = 1'b1; reset64 = 1'b1;
      @(negedge clk);

      // 3+4 with ignored start pulses mid-RUN and during DONE
      issue8(8'h03, 8'h04, 1'b0, 1'b1, mk(64'h07, 0, 0, 0, 0));
      repeat (3) @(negedge clk);
      a8 = 8'hAA; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(5, "latency8_3p4");
      chk("ready8_in_done", 64'(ready8), 64'd0);
      a8 = 8'hAA; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("ready8_after_done", 64'(ready8), 64'd1);
      chk("done8_single", 64'(done8), 64'd0);
      repeat (2) @(negedge clk);
      chk("busy8_no_queue", 64'(busy8), 64'd0);

      issue8(8'h7F, 8'h01, 1'b0, 1'b1, mk(64'h80, 1, 0, 0, 1));
      wait_done8(1, "latency8_7f");
      issue8(8'hFF, 8'h01, 1'b0, 1'b1, mk(64'h00, 0, 1, 1, 0));
      wait_done8(1, "latency8_ff");
      issue8(8'h05, 8'h05, 1'b1, 1'b1, mk(64'h00, 0, 1, 1, 0));
      wait_done8(1, "latency8_sub0");
      issue8(8'h80, 8'h01, 1'b1, 1'b1, mk(64'h7F, 0, 0, 1, 1));
      wait_done8(1, "latency8_sub80");

      // Abort mid-RUN; the discarded op has no expectation queued
      issue8(8'h10, 8'h20, 1'b0, 1'b0, mk(64'h0, 0, 0, 0, 0));
      repeat (4) @(negedge clk);
      #2 reset8 = 1'b0;
      #1 chk_idle8("abort8");
      @(negedge clk);
      reset8 = 1'b1;
      issue8(8'h02, 8'h02, 1'b0, 1'b1, mk(64'h04, 0, 0, 0, 0));
      wait_done8(1, "latency8_after_abort");
      @(negedge clk);

      // 64-bit back-to-back run with start held high
      begin
         int issued = 0;
         int guard  = 0;
         start64 = 1'b1;
         while (issued < NOPS && guard < 80000) begin
            if (ready64 === 1'b1) begin
               a64   = {$urandom(), $urandom()};
               b64   = (issued % 7 == 3) ? a64 : {$urandom(), $urandom()};
               sub64 = 1'($urandom_range(0, 1));
               q64.push_back(model64(a64, b64, sub64));
               issued++;
            end
            @(negedge clk);
            guard++;
         end
         start64 = 1'b0;
         chk("issued64", 64'(issued), 64'(NOPS));
         guard = 0;
         while (q64.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         chk("drain64", 64'(q64.size()), 64'd0);
         chk("drain8", 64'(q8.size()), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
